// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key-schedule slice: word types, word
// positions inside a 128-bit key, the forward S-box table and the Rcon lookup.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  // Word 0 sits in the most significant 32 bits of a key.
  localparam int W0_MSB = 127;
  localparam int W1_MSB = 95;
  localparam int W2_MSB = 63;
  localparam int W3_MSB = 31;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant byte; rounds outside 1..10 contribute nothing.
  function automatic byte_t rcon_byte(input logic [3:0] round);
    byte_t rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One round of AES-128 key expansion, forward (dir=0) or inverse (dir=1),
// sharing a single RotWord/SubWord/Rcon path between both directions.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = SBOX[in_byte];
endmodule

module aes_rcon
  import aes_pkg::*;
(
  input  logic [3:0]  round,
  output logic [31:0] rcon
);
  assign rcon = {rcon_byte(round), 24'h000000};
endmodule

module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   round,
  input  logic         dir,
  output logic [127:0] next_key
);
  word_t w0_s, w1_s, w2_s, w3_s;
  word_t sub_in_s, rot_s, sub_s, rcon_s, t_s;
  word_t n0_s, n1_s, n2_s, n3_s;

  assign w0_s = key[W0_MSB -: 32];
  assign w1_s = key[W1_MSB -: 32];
  assign w2_s = key[W2_MSB -: 32];
  assign w3_s = key[W3_MSB -: 32];

  // Going backwards, the old w3 is only recoverable as w3 ^ w2.
  assign sub_in_s = dir ? (w3_s ^ w2_s) : w3_s;
  assign rot_s    = {sub_in_s[23:0], sub_in_s[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_s[8*b +: 8]),
      .out_byte (sub_s[8*b +: 8])
    );
  end

  aes_rcon u_rcon (
    .round (round),
    .rcon  (rcon_s)
  );

  assign t_s = sub_s ^ rcon_s;

  // Word recurrence: forward chains w0..w3, inverse undoes it from w3 down.
  always_comb begin
    n0_s = w0_s;
    n1_s = w1_s;
    n2_s = w2_s;
    n3_s = w3_s;
    if (dir) begin
      n3_s = w3_s ^ w2_s;
      n2_s = w2_s ^ w1_s;
      n1_s = w1_s ^ w0_s;
      n0_s = w0_s ^ t_s;
    end else begin
      n0_s = w0_s ^ t_s;
      n1_s = w1_s ^ n0_s;
      n2_s = w2_s ^ n1_s;
      n3_s = w3_s ^ n2_s;
    end
  end

  assign next_key = {n0_s, n1_s, n2_s, n3_s};
endmodule

// File: rtl/aes_inv_key_sched.sv
// Decryption-side AES-128 key scheduler: expands forward to round 10, then
// walks the expansion backwards, handing out one round key per handshake.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [1:0]   state_r;
  logic [127:0] key_r;
  logic [3:0]   cnt_r;
  logic         key_valid_r, busy_r, done_r;
  logic [127:0] next_key_s;
  logic         dir_s, accept_s;

  assign dir_s    = (state_r == ST_EMIT);
  assign accept_s = key_valid_r & key_ready;

  aes_key_step u_step (
    .key      (key_r),
    .round    (cnt_r),
    .dir      (dir_s),
    .next_key (next_key_s)
  );

  // Schedule FSM, key register and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      key_r       <= 128'h0;
      cnt_r       <= 4'd0;
      key_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            key_r   <= cipher_key;
            cnt_r   <= 4'd1;
            busy_r  <= 1'b1;
            state_r <= ST_FWD;
          end
        end
        ST_FWD: begin
          key_r <= next_key_s;
          if (cnt_r == LAST_ROUND) begin
            state_r     <= ST_EMIT;
            key_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_EMIT: begin
          if (accept_s) begin
            if (cnt_r != 4'd0) begin
              key_r <= next_key_s;
              cnt_r <= cnt_r - 4'd1;
            end else begin
              state_r     <= ST_IDLE;
              key_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          key_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign key_valid = key_valid_r;
  assign round_key = key_r;
  assign round_idx = cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomized bench for aes_inv_key_sched against a textbook AES-128 key
// expansion model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cipher_key = 128'h0;
  logic         key_ready = 1'b0;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   ref_sbox [256];
  logic [127:0] rk  [11];
  logic [127:0] cap [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_inv_key_sched #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cipher_key (cipher_key),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      ref_sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_valid"}, key_valid, 1'b0);
    check_val({tag, "_key"}, round_key, 128'h0);
    check_val({tag, "_idx"}, round_idx, 4'd0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
  endtask

  // Called at a falling edge; presents start and waits for the first round key.
  task automatic launch(input logic [127:0] key, input bit glitch);
    int lat;
    build_model(key);
    start = 1'b1;
    cipher_key = key;
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    check_val("busy_after_start", busy, 1'b1);
    while (!key_valid && lat < 40) begin
      if (glitch) begin
        start = 1'($urandom_range(1));
        cipher_key = rand_key();
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_val("start_latency", 128'(lat), 128'd11);
  endtask

  task automatic emit(input int pct, input bit glitch, input bit chain, input int abort_idx);
    int r = 10;
    int cyc = 0;
    bit rdy;
    bit finished = 1'b0;
    while (!finished && cyc < 500) begin
      check_val("key_valid", key_valid, 1'b1);
      check_val("round_idx", round_idx, 128'(r));
      check_val("round_key", round_key, rk[r]);
      cap[r] = round_key;
      if (r == abort_idx) begin
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        check_val("abort_no_done", done, 1'b0);
        key_ready = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("after_abort");
        return;
      end
      rdy = ($urandom_range(99) < pct);
      key_ready = rdy;
      if (glitch) begin
        start = 1'($urandom_range(1));
        cipher_key = rand_key();
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (rdy) begin
        if (r == 0) begin
          check_val("done_pulse", done, 1'b1);
          check_val("valid_after_last", key_valid, 1'b0);
          check_val("busy_after_last", busy, 1'b0);
          if (pct == 100) check_val("zero_bubble_cycles", 128'(cyc), 128'd11);
          finished = 1'b1;
          key_ready = 1'b0;
          if (!chain) begin
            @(negedge clk);
            check_val("done_one_cycle", done, 1'b0);
          end
        end else begin
          r--;
        end
      end
    end
    check_val("emit_finished", finished, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    build_sbox();
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 key, consumer always ready.
    launch(FIPS_KEY, 1'b0);
    emit(100, 1'b0, 1'b0, -1);
    check_val("fips_idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_val("fips_idx9",  cap[9],  128'hac7766f319fadc2128d12941575c006e);
    check_val("fips_idx1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check_val("fips_idx0",  cap[0],  FIPS_KEY);

    // Same key, sparse consumer.
    launch(FIPS_KEY, 1'b0);
    emit(30, 1'b0, 1'b0, -1);

    // Spurious start pulses with other keys while busy.
    launch(FIPS_KEY, 1'b1);
    emit(50, 1'b1, 1'b0, -1);

    // All-zero key.
    launch(128'h0, 1'b0);
    emit(100, 1'b0, 1'b0, -1);
    check_val("zero_idx10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check_val("zero_idx0",  cap[0],  128'h0);

    // Reset during emission at round 6, then a clean run.
    launch(FIPS_KEY, 1'b0);
    emit(100, 1'b0, 1'b0, 6);
    launch(FIPS_KEY, 1'b0);
    emit(100, 1'b0, 1'b0, -1);

    // Back-to-back: start in the done cycle.
    launch(rand_key(), 1'b0);
    emit(100, 1'b0, 1'b1, -1);
    launch(rand_key(), 1'b0);
    emit(70, 1'b0, 1'b0, -1);

    // Random keys with random consumer duty.
    for (int n = 0; n < 4; n++) begin
      k = rand_key();
      launch(k, n[0]);
      emit(int'($urandom_range(20, 100)), n[0], 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
